bin2bcd_conv: RTL and testbench

BIN2BCD_CONV -- requirements
Module: bin2bcd_conv

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bin2bcd_conv.sv | 125 ++++++++++++
 tb/tb_bin2bcd_conv.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the bin2bcd_conv converter: FSM encoding, digit counts,
// double-dabble adjust constants and the saturation pattern.
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned BCD_DIGITS     = 8;
    localparam int unsigned BCD_ACC_DIGITS = 10;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    localparam logic [31:0] SAT_VALUE = 32'h99999999;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= ADJ_THRESH) begin
            o_digit = i_digit + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Optional macro BCD_SAT_EN saturates o_bcd to 99999999 on overflow.
module bin2bcd_conv
    import bcd_pkg::*;
#(
    parameter int unsigned IN_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IN_W-1:0] i_bin,
    output logic            busy,
    output logic            o_valid,
    output logic [31:0]     o_bcd,
    output logic            o_ovf
);

    localparam int unsigned ACC_W = BCD_ACC_DIGITS * 4;
    localparam int unsigned OUT_W = BCD_DIGITS * 4;
    localparam int unsigned CNT_W = 6;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   bin_q, bin_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [OUT_W-1:0]  bcd_q, bcd_d;
    logic              ovf_q, ovf_d;

    logic [ACC_W-1:0]      acc_adj;
    logic [ACC_W+IN_W-1:0] shift_all;
    logic [ACC_W-1:0]      acc_shift;
    logic [IN_W-1:0]       bin_shift;
    logic                  ovf_raw;
    logic [OUT_W-1:0]      bcd_res;

    for (genvar g = 0; g < BCD_ACC_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (acc_q[4*g +: 4]),
            .o_digit (acc_adj[4*g +: 4])
        );
    end

    assign shift_all = {acc_adj, bin_q} << 1;
    assign acc_shift = shift_all[ACC_W+IN_W-1 -: ACC_W];
    assign bin_shift = shift_all[IN_W-1:0];

    // Inputs narrower than 27 bits can never reach 10^8.
    if (IN_W >= 27) begin : g_ovf
        assign ovf_raw = |acc_shift[ACC_W-1:OUT_W];
    end else begin : g_no_ovf
        assign ovf_raw = 1'b0;
    end

`ifdef BCD_SAT_EN
    assign bcd_res = ovf_raw ? SAT_VALUE : acc_shift[OUT_W-1:0];
`else
    assign bcd_res = acc_shift[OUT_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = i_bin;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(IN_W);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_shift;
                bin_d = bin_shift;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = bcd_res;
                    ovf_d   = ovf_raw;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy    = busy_q;
    assign o_valid = valid_q;
    assign o_bcd   = bcd_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Self-checking bench for bin2bcd_conv: vector table, back-to-back requests and
// mid-conversion reset, with results matched against a scoreboard queue.
module tb_bin2bcd_conv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] i_bin;
    logic         busy;
    logic         o_valid;
    logic [31:0]  o_bcd;
    logic         o_ovf;

    always #5 clk = ~clk;

    bin2bcd_conv #(.IN_W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .i_bin   (i_bin),
        .busy    (busy),
        .o_valid (o_valid),
        .o_bcd   (o_bcd),
        .o_ovf   (o_ovf)
    );

    typedef struct packed {
        logic [31:0] bcd;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [31:0] bin;
        logic [31:0] bcd;
        logic        ovf;
    } vec_t;

`ifdef BCD_SAT_EN
    localparam logic [31:0] EXP_1E8   = 32'h99999999;
    localparam logic [31:0] EXP_1E8P1 = 32'h99999999;
    localparam logic [31:0] EXP_FFFF  = 32'h99999999;
`else
    localparam logic [31:0] EXP_1E8   = 32'h00000000;
    localparam logic [31:0] EXP_1E8P1 = 32'h00000001;
    localparam logic [31:0] EXP_FFFF  = 32'h94967295;
`endif

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_valid_cyc = -1;
    bit   spacing_en = 1'b0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] v);
        exp_t            r;
        longint unsigned x;
        longint unsigned m;
        x     = 64'(v);
        r.ovf = (x >= 64'd100000000);
        m     = x % 64'd100000000;
        r.bcd = '0;
        for (int i = 0; i < 8; i++) begin
            r.bcd[i*4 +: 4] = 4'(m % 64'd10);
            m = m / 64'd10;
        end
`ifdef BCD_SAT_EN
        if (r.ovf) r.bcd = 32'h99999999;
`endif
        return r;
    endfunction

    // Every o_valid pulse must be expected, single-cycle, and carry the queued result.
    always @(negedge clk) begin
        if (o_valid) begin
            check("valid_width", {31'b0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got o_valid=1 (o_bcd %h) expected no pulse", o_bcd);
            end else begin
                mon_e = exp_q.pop_front();
                check("o_bcd", o_bcd, mon_e.bcd);
                check("o_ovf", {31'b0, o_ovf}, {31'b0, mon_e.ovf});
                // The next request is sampled at the end of the o_valid cycle.
                if (spacing_en && last_valid_cyc >= 0)
                    check("result_spacing", 32'(cyc - last_valid_cyc), 32'(W + 1));
            end
            last_valid_cyc = cyc;
        end
        prev_valid = o_valid;
    end

    task automatic run_conv(input logic [31:0] bin, input logic [31:0] eb, input logic eo);
        int n      = 0;
        int busy_n = 0;
        bit got    = 1'b0;
        @(negedge clk);
        start = 1'b1;
        i_bin = bin;
        exp_q.push_back({eb, eo});
        @(posedge clk);
        #1;
        start = 1'b0;
        i_bin = $urandom();
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            if (o_valid) begin
                n   = k;
                got = 1'b1;
                break;
            end
            if (busy) busy_n++;
            @(posedge clk);
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_timeout: got no o_valid within 100 cycles for %h", bin);
        end else begin
            check("latency", 32'(n), 32'(W));
            check("busy_cycles", 32'(busy_n), 32'(W));
            check("busy_at_valid", {31'b0, busy}, 32'd0);
        end
        repeat (3) @(negedge clk);
        check("hold_bcd", o_bcd, eb);
        check("hold_ovf", {31'b0, o_ovf}, {31'b0, eo});
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'd0,          32'h00000000, 1'b0};
        vecs[1] = '{32'd12345678,   32'h12345678, 1'b0};
        vecs[2] = '{32'd99999999,   32'h99999999, 1'b0};
        vecs[3] = '{32'd100000000,  EXP_1E8,      1'b1};
        vecs[4] = '{32'hFFFFFFFF,   EXP_FFFF,     1'b1};
        vecs[5] = '{32'd1,          32'h00000001, 1'b0};
        vecs[6] = '{32'd9,          32'h00000009, 1'b0};
        vecs[7] = '{32'd10,         32'h00000010, 1'b0};
        vecs[8] = '{32'd65535,      32'h00065535, 1'b0};
        vecs[9] = '{32'd100000001,  EXP_1E8P1,    1'b1};

        reset = 1'b1;
        start = 1'b0;
        i_bin = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  {31'b0, busy},    32'd0);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_bcd",   o_bcd,            32'd0);
        check("rst_ovf",   {31'b0, o_ovf},   32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);

        // start held high with a changing input: only IDLE/o_valid-cycle samples convert
        spacing_en     = 1'b1;
        last_valid_cyc = -1;
        for (int e = 0; e <= 3 * (W + 1); e++) begin
            @(negedge clk);
            start = 1'b1;
            i_bin = 32'd90000000 + 32'(e) * 32'd1234567;
            if (e % (W + 1) == 0) exp_q.push_back(model(i_bin));
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);
        spacing_en = 1'b0;

        // Abort after 10 shifts, with start asserted alongside reset.
        @(negedge clk);
        start = 1'b1;
        i_bin = 32'd55555555;
        @(posedge clk);
        #1;
        i_bin = $urandom();
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy",  {31'b0, busy},    32'd0);
        check("abort_valid", {31'b0, o_valid}, 32'd0);
        check("abort_bcd",   o_bcd,            32'd0);
        check("abort_ovf",   {31'b0, o_ovf},   32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_over_start", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("post_abort_bcd", o_bcd, 32'd0);
        run_conv(32'd87654321, 32'h87654321, 1'b0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000 expected earlier finish");
        $fatal(1);
    end

endmodule
